// File: rtl/bal_cntrl_gen2_if.sv
// rtl/bal_cntrl_gen2_if.sv - signal bundle for the balance controller
// Purpose: groups the sensor/command inputs and motor outputs of bal_cntrl_gen2.
// Ports:
//   vld, ptch, ptch_rt         pitch sample strobe, signed pitch, signed pitch rate
//   pwr_up, rider_off          enable and rider-absent controls
//   steer_pot, en_steer        unsigned steering pot reading and its enable
//   lft_spd, rght_spd          signed OUT_W motor speed commands
//   too_fast, integ_sat        overspeed flag, integrator-blocked pulse
interface bal_cntrl_gen2_if #(
  parameter int OUT_W = 12
);
  logic                    vld;
  logic signed [15:0]      ptch;
  logic signed [15:0]      ptch_rt;
  logic                    pwr_up;
  logic                    rider_off;
  logic [11:0]             steer_pot;
  logic                    en_steer;
  logic signed [OUT_W-1:0] lft_spd;
  logic signed [OUT_W-1:0] rght_spd;
  logic                    too_fast;
  logic                    integ_sat;

  modport master (
    output vld, ptch, ptch_rt, pwr_up, rider_off, steer_pot, en_steer,
    input  lft_spd, rght_spd, too_fast, integ_sat
  );

  modport slave (
    input  vld, ptch, ptch_rt, pwr_up, rider_off, steer_pot, en_steer,
    output lft_spd, rght_spd, too_fast, integ_sat
  );
endinterface

// File: rtl/bal_cntrl_gen2.sv
// rtl/bal_cntrl_gen2.sv - PID balance controller with soft-start and steering mix
// Purpose: PID on pitch samples, soft-start scaling, steering mix, saturated motor outputs.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    bal_cntrl_gen2_if.slave (pitch inputs, controls, motor outputs, flags)
module bal_cntrl_gen2 #(
  parameter int FAST_SIM    = 1,
  parameter int OUT_W       = 12,
  parameter int SS_DIV      = 256,
  parameter int TOO_FAST_TH = 1536
) (
  input logic             clk,
  input logic             rst_n,
  bal_cntrl_gen2_if.slave bus
);
  localparam int          SW   = OUT_W + 1;
  localparam logic [31:0] TH_U = 32'(TOO_FAST_TH);

  logic                    clr;
  logic signed [9:0]       sat_ptch;
  logic signed [17:0]      integ, integ_sum, integ_nxt;
  logic                    integ_ovf;
  logic                    integ_sat_q;
  logic signed [9:0]       rt_shift;
  logic signed [14:0]      p_term, i_term, d_term;
  logic signed [16:0]      pid_sum;
  logic signed [11:0]      pid_sat, pid_cntrl;
  logic [15:0]             prescale;
  logic [7:0]              ss_tmr;
  logic signed [20:0]      pid_prod;
  logic signed [12:0]      pid_ss;
  logic [11:0]             pot_clip;
  logic signed [12:0]      steer_ofs;
  logic signed [14:0]      steer_x3;
  logic signed [10:0]      steer;
  logic signed [SW-1:0]    pid_ss_w, steer_w, lft_raw, rght_raw;
  logic signed [OUT_W-1:0] lft_q, rght_q;
  logic                    too_fast_q, too_fast_nxt;
  logic                    unused_bits;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SW-1:0] v);
    // Overflow into OUT_W shows up as disagreement of the top two bits.
    if (v[SW-1] != v[SW-2])
      return {v[SW-1], {(OUT_W-1){~v[SW-1]}}};
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [SW-1:0] mag(input logic signed [SW-1:0] v);
    return v[SW-1] ? -v : v;
  endfunction

  assign clr = bus.rider_off | ~bus.pwr_up;

  always_comb begin
    if (bus.ptch > 16'sd511)
      sat_ptch = 10'sd511;
    else if (bus.ptch < -16'sd512)
      sat_ptch = -10'sd512;
    else
      sat_ptch = bus.ptch[9:0];
  end

  assign integ_sum = integ + 18'(sat_ptch);
  assign integ_ovf = (integ[17] == sat_ptch[9]) && (integ_sum[17] != integ[17]);

  always_comb begin
    integ_nxt = integ;
    if (clr)
      integ_nxt = '0;
    else if (bus.vld && !integ_ovf)
      integ_nxt = integ_sum;
  end

  // I term sees the integrator value being written on this same edge.
  always_comb begin
    if (FAST_SIM != 0)
      i_term = integ_nxt[16:2];
    else
      i_term = {{3{integ_nxt[17]}}, integ_nxt[17:6]};
  end

  assign rt_shift = bus.ptch_rt[15:6];
  assign p_term   = 15'(sat_ptch) * 15'sd5;
  assign d_term   = -15'(rt_shift);
  assign pid_sum  = 17'(p_term) + 17'(i_term) + 17'(d_term);

  always_comb begin
    if (pid_sum > 17'sd2047)
      pid_sat = 12'sd2047;
    else if (pid_sum < -17'sd2048)
      pid_sat = -12'sd2048;
    else
      pid_sat = pid_sum[11:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ       <= '0;
      pid_cntrl   <= '0;
      integ_sat_q <= 1'b0;
    end else begin
      integ       <= integ_nxt;
      integ_sat_q <= !clr && bus.vld && integ_ovf;
      if (clr)
        pid_cntrl <= '0;
      else if (bus.vld)
        pid_cntrl <= pid_sat;
    end
  end

  // Soft-start: ss_tmr ramps 0..255, one step per SS_DIV clocks of pwr_up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      ss_tmr   <= '0;
    end else if (!bus.pwr_up) begin
      prescale <= '0;
      ss_tmr   <= '0;
    end else if (prescale == 16'(SS_DIV - 1)) begin
      prescale <= '0;
      if (ss_tmr != 8'hFF)
        ss_tmr <= ss_tmr + 8'd1;
    end else begin
      prescale <= prescale + 16'd1;
    end
  end

  // Upper bits of the product are the floor of the divide by 256.
  assign pid_prod = 21'(pid_cntrl) * $signed({13'd0, ss_tmr});
  assign pid_ss   = pid_prod[20:8];

  always_comb begin
    if (bus.steer_pot < 12'h200)
      pot_clip = 12'h200;
    else if (bus.steer_pot > 12'hE00)
      pot_clip = 12'hE00;
    else
      pot_clip = bus.steer_pot;
  end

  assign steer_ofs = 13'(pot_clip) - 13'sd2047;
  assign steer_x3  = 15'(steer_ofs) * 15'sd3;
  assign steer     = steer_x3[14:4];

  assign pid_ss_w = SW'(pid_ss);
  assign steer_w  = bus.en_steer ? SW'(steer) : '0;
  assign lft_raw  = pid_ss_w + steer_w;
  assign rght_raw = pid_ss_w - steer_w;

  assign too_fast_nxt = (32'(mag(lft_raw)) > TH_U) || (32'(mag(rght_raw)) > TH_U);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q      <= '0;
      rght_q     <= '0;
      too_fast_q <= 1'b0;
    end else if (!bus.pwr_up) begin
      lft_q      <= '0;
      rght_q     <= '0;
      too_fast_q <= 1'b0;
    end else begin
      lft_q      <= sat_out(lft_raw);
      rght_q     <= sat_out(rght_raw);
      too_fast_q <= too_fast_nxt;
    end
  end

  assign bus.lft_spd   = lft_q;
  assign bus.rght_spd  = rght_q;
  assign bus.too_fast  = too_fast_q;
  assign bus.integ_sat = integ_sat_q;

  // Fractional bits dropped by the arithmetic shifts.
  assign unused_bits = ^{pid_prod[7:0], steer_x3[3:0], bus.ptch_rt[5:0]};
endmodule

// File: tb/tb_bal_cntrl_gen2.sv
// tb/tb_bal_cntrl_gen2.sv - self-checking bench for bal_cntrl_gen2
module tb_bal_cntrl_gen2;
  localparam int SS_DIV = 4;
  localparam int TH     = 1536;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bal_cntrl_gen2_if #(.OUT_W(12)) bus ();

  bal_cntrl_gen2 #(
    .FAST_SIM(1), .OUT_W(12), .SS_DIV(SS_DIV), .TOO_FAST_TH(TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ptch;
    logic [15:0] ptch_rt;
    logic [11:0] pot;
    logic        en;
    int          lft;
    int          rght;
    int          tf;
  } vec_t;

  vec_t vt[10];

  // Reference state: integrator, PID register, clocks since pwr_up, registered outputs.
  int m_integ, m_pid, m_on, m_lft, m_rght, m_tf, m_isat;

  function automatic int clip(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int wrap15(input int v);
    int t;
    t = v & 32'h7FFF;
    return (t >= 16384) ? t - 32768 : t;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ss_of(input int on);
    return (on / SS_DIV > 255) ? 255 : on / SS_DIV;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_integ = 0; m_pid = 0; m_on = 0;
    m_lft = 0; m_rght = 0; m_tf = 0; m_isat = 0;
  endtask

  // One clock of the reference: outputs from pre-edge PID and ramp, then state update.
  task automatic model_step();
    int ss, pss, st, l, r, sp, s, i_t, d_t;
    ss = ss_of(m_on);
    if (!bus.pwr_up) begin
      m_lft = 0; m_rght = 0; m_tf = 0;
    end else begin
      pss = (m_pid * ss) >>> 8;
      st  = bus.en_steer ? (((clip(int'(bus.steer_pot), 512, 3584) - 2047) * 3) >>> 4) : 0;
      l   = pss + st;
      r   = pss - st;
      m_tf   = (iabs(l) > TH || iabs(r) > TH) ? 1 : 0;
      m_lft  = clip(l, -2048, 2047);
      m_rght = clip(r, -2048, 2047);
    end
    m_isat = 0;
    if (bus.rider_off || !bus.pwr_up) begin
      m_integ = 0;
      m_pid   = 0;
    end else if (bus.vld) begin
      sp = clip(int'(bus.ptch), -512, 511);
      s  = m_integ + sp;
      if (s > 131071 || s < -131072) m_isat = 1;
      else m_integ = s;
      i_t   = wrap15(m_integ >>> 2);
      d_t   = -(int'(bus.ptch_rt) >>> 6);
      m_pid = clip(5 * sp + i_t + d_t, -2048, 2047);
    end
    m_on = bus.pwr_up ? m_on + 1 : 0;
  endtask

  task automatic check_model();
    chk("lft_model", int'(bus.lft_spd), m_lft);
    chk("rght_model", int'(bus.rght_spd), m_rght);
    chk("too_fast_model", int'(bus.too_fast), m_tf);
    chk("integ_sat_model", int'(bus.integ_sat), m_isat);
    chk("integ_model", int'(dut.integ), m_integ);
    chk("ss_tmr_model", int'(dut.ss_tmr), ss_of(m_on));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_lft", int'(bus.lft_spd), 0);
    chk("rst_rght", int'(bus.rght_spd), 0);
    chk("rst_too_fast", int'(bus.too_fast), 0);
    chk("rst_integ_sat", int'(bus.integ_sat), 0);
    chk("rst_ss_tmr", int'(dut.ss_tmr), 0);
    chk("rst_integ", int'(dut.integ), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int tmp;
    logic seen;

    vt[0] = '{16'h0064, 16'h0000, 12'h000, 1'b0,   522,   522, 0};
    vt[1] = '{16'h7FFF, 16'h0000, 12'h000, 1'b0,  2039,  2039, 1};
    vt[2] = '{16'h0000, 16'h0000, 12'hFFF, 1'b1,   288,  -288, 0};
    vt[3] = '{16'h0000, 16'h0000, 12'hFFF, 1'b0,     0,     0, 0};
    vt[4] = '{16'hFF9C, 16'h0000, 12'h000, 1'b0,  -523,  -523, 0};
    vt[5] = '{16'h0000, 16'h0280, 12'h000, 1'b0,   -10,   -10, 0};
    vt[6] = '{16'h8000, 16'h0000, 12'h000, 1'b1, -2048, -1752, 1};
    vt[7] = '{16'h00C8, 16'h0000, 12'h7FF, 1'b1,  1045,  1045, 0};
    vt[8] = '{16'h012C, 16'h0000, 12'hE00, 1'b1,  1856,  1280, 1};
    vt[9] = '{16'h0000, 16'h8000, 12'h000, 1'b0,   510,   510, 0};

    bus.vld = 0; bus.ptch = 0; bus.ptch_rt = 0; bus.pwr_up = 0;
    bus.rider_off = 0; bus.steer_pot = 0; bus.en_steer = 0;
    model_reset();
    apply_reset();

    // Soft-start ramp with zero inputs.
    bus.pwr_up = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("ss_after_4", int'(dut.ss_tmr), 1);
    for (int i = 4; i < 300; i++) tick();
    chk("zero_in_lft", int'(bus.lft_spd), 0);
    chk("zero_in_rght", int'(bus.rght_spd), 0);
    chk("zero_in_too_fast", int'(bus.too_fast), 0);
    for (int i = 300; i < 1019; i++) tick();
    chk("ss_after_1019", int'(dut.ss_tmr), 254);
    tick();
    chk("ss_after_1020", int'(dut.ss_tmr), 255);

    // Table: clear, one vld, one hold clock, then compare.
    for (int i = 0; i < 10; i++) begin
      bus.rider_off = 1; bus.vld = 0;
      tick();
      bus.rider_off = 0;
      bus.ptch = vt[i].ptch; bus.ptch_rt = vt[i].ptch_rt;
      bus.steer_pot = vt[i].pot; bus.en_steer = vt[i].en;
      bus.vld = 1;
      tick();
      bus.vld = 0;
      tick();
      chk($sformatf("vec%0d_lft", i), int'(bus.lft_spd), vt[i].lft);
      chk($sformatf("vec%0d_rght", i), int'(bus.rght_spd), vt[i].rght);
      chk($sformatf("vec%0d_too_fast", i), int'(bus.too_fast), vt[i].tf);
    end

    // Integrator overflow: 256 adds of 511 reach 130816, the 257th must be blocked.
    bus.en_steer = 0; bus.ptch_rt = 0;
    bus.rider_off = 1; tick(); bus.rider_off = 0;
    bus.ptch = 16'sd511; bus.vld = 1;
    n = 0; seen = 1'b0;
    while (n < 300 && !seen) begin
      tick();
      n++;
      if (bus.integ_sat) seen = 1'b1;
    end
    chk("ovf_vld_count", n, 257);
    chk("ovf_integ_hold", int'(dut.integ), 130816);
    bus.vld = 0;
    tick();
    chk("ovf_pulse_end", int'(bus.integ_sat), 0);
    chk("ovf_integ_still", int'(dut.integ), 130816);
    bus.rider_off = 1;
    tick();
    chk("rider_off_integ", int'(dut.integ), 0);
    bus.rider_off = 0;

    // Simultaneous vld and rider_off.
    bus.ptch = 16'sd300; bus.vld = 1;
    tick();
    bus.rider_off = 1;
    tick();
    chk("simul_integ", int'(dut.integ), 0);
    chk("simul_pid", int'(dut.pid_cntrl), 0);
    bus.rider_off = 0; bus.vld = 0;

    // pwr_up drop forces outputs to zero even with steering on.
    bus.en_steer = 1; bus.steer_pot = 12'hFFF; bus.vld = 1;
    tick();
    bus.vld = 0;
    tick();
    bus.pwr_up = 0;
    tick();
    chk("pwr_dn_lft", int'(bus.lft_spd), 0);
    chk("pwr_dn_rght", int'(bus.rght_spd), 0);
    chk("pwr_dn_too_fast", int'(bus.too_fast), 0);

    // Reset mid-ramp, then the ramp restarts from zero.
    bus.pwr_up = 1; bus.vld = 1;
    tick();
    bus.vld = 0;
    for (int i = 0; i < 50; i++) tick();
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    chk("ss_restart_4", int'(dut.ss_tmr), 1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 2000; i++) begin
      bus.pwr_up    = ($urandom_range(0, 99) != 0);
      bus.rider_off = ($urandom_range(0, 49) == 0);
      bus.vld       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        bus.ptch = 16'($urandom);
      end else begin
        tmp = int'($urandom_range(0, 1400)) - 700;
        bus.ptch = 16'(tmp);
      end
      bus.ptch_rt   = 16'($urandom);
      bus.steer_pot = 12'($urandom);
      bus.en_steer  = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
